// File: rtl/control_sequencer_if.sv
// Control bus between the control sequencer and the CPU datapath.
// The sequencer drives the strobes; the datapath side supplies the
// run enable, the IR opcode field and the ROM/ALU handshakes.
interface control_sequencer_if #(
    parameter int OPCODE_W = 4
);
    // Datapath -> sequencer
    logic                en;
    logic [OPCODE_W-1:0] opcode;
    logic                ins_valid;
    logic                alu_done;

    // Sequencer -> datapath
    logic [1:0]          alu_ot;
    logic                ins_load;
    logic                op1_load;
    logic                op2_load;
    logic                pc_load;
    logic                pc_inc;
    logic                reg_load;
    logic [1:0]          word_idx;
    logic                busy;
    logic                halted;
    logic                fault;

    modport master (
        input  en, opcode, ins_valid, alu_done,
        output alu_ot, ins_load, op1_load, op2_load, pc_load, pc_inc,
               reg_load, word_idx, busy, halted, fault
    );

    modport slave (
        output en, opcode, ins_valid, alu_done,
        input  alu_ot, ins_load, op1_load, op2_load, pc_load, pc_inc,
               reg_load, word_idx, busy, halted, fault
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the 16-bit CPU: fetch, decode, execute and
// write-back with handshaked fetch, 1..3 word instructions, multi-cycle
// ALU ops, pause, halt and fault handling (illegal opcode, timeout).
module control_sequencer #(
    parameter int OPCODE_W        = 4,
    parameter int TIMEOUT         = 16,
    parameter bit MULTI_CYCLE_ALU = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    control_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ALU_ADDR  = 2'b00;
    localparam logic [1:0] ALU_ARITH = 2'b01;
    localparam logic [1:0] ALU_LOGIC = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_INS,
        S_EXEC,
        S_ALU_WAIT,
        S_EXT_FETCH,
        S_EXT_WAIT,
        S_EXT_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_MUL  = 4'h1,
        OP_SUB  = 4'h2,
        OP_DIV  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NOR  = 4'h6,
        OP_INV1 = 4'h7,
        OP_INV2 = 4'h8,
        OP_XOR  = 4'h9,
        OP_XNOR = 4'hA,
        OP_MOV  = 4'hB,
        OP_MVI  = 4'hC,
        OP_LDA  = 4'hD,
        OP_LDX  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_t;

    // What the EXEC state has to do for the opcode sitting in the IR.
    typedef struct packed {
        logic [1:0] alu_ot;     // ALU mode during EXEC
        logic       op1_load;
        logic       op2_load;
        logic       alu_wait;   // park in ALU_WAIT until alu_done
        logic       ext;        // multi-word: more words follow
        logic [1:0] last_word;  // index of the final word (ext only)
        logic       halt;
        logic       illegal;
    } decode_t;

    state_t     state_q, state_d;
    logic [1:0] word_idx_q, word_idx_d;
    logic [1:0] last_word_q, last_word_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic       fault_q, fault_d;

    logic [1:0] alu_ot_c;
    logic       ins_load_c;
    logic       op1_load_c;
    logic       op2_load_c;
    logic       pc_load_c;
    logic       pc_inc_c;
    logic       reg_load_c;

    logic [3:0] op_low;
    logic       op_upper_set;
    logic       tmo_hit;
    decode_t    dec;

    assign op_low  = bus.opcode[3:0];
    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT));

    // Any set bit above the 4-bit opcode field marks the instruction illegal.
    if (OPCODE_W > 4) begin : g_wide_opcode
        assign op_upper_set = |bus.opcode[OPCODE_W-1:4];
    end else begin : g_narrow_opcode
        assign op_upper_set = 1'b0;
    end

    function automatic logic is_wait(input state_t s);
        return (s == S_WAIT_INS) || (s == S_ALU_WAIT) || (s == S_EXT_WAIT);
    endfunction

    // Opcode decode: classify the instruction for the EXEC state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path can leave one unassigned and infer a latch.
        dec = '0;
        unique case (opcode_t'(op_low))
            OP_ADD, OP_SUB: begin
                dec.alu_ot   = ALU_ARITH;
                dec.op1_load = 1'b1;
                dec.op2_load = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                dec.alu_ot   = ALU_ARITH;
                dec.op1_load = 1'b1;
                dec.op2_load = 1'b1;
                dec.alu_wait = MULTI_CYCLE_ALU;
            end
            OP_AND, OP_OR, OP_NOR, OP_XOR, OP_XNOR: begin
                dec.alu_ot   = ALU_LOGIC;
                dec.op1_load = 1'b1;
                dec.op2_load = 1'b1;
            end
            OP_INV1: begin
                dec.alu_ot   = ALU_LOGIC;
                dec.op1_load = 1'b1;
            end
            OP_INV2: begin
                dec.alu_ot   = ALU_LOGIC;
                dec.op2_load = 1'b1;
            end
            OP_MOV: begin
                dec.alu_ot   = ALU_ADDR;
                dec.op1_load = 1'b1;
                dec.op2_load = 1'b1;
            end
            OP_MVI: begin
                dec.op1_load  = 1'b1;
                dec.ext       = 1'b1;
                dec.last_word = 2'd1;
            end
            OP_LDA: begin
                dec.ext       = 1'b1;
                dec.last_word = 2'd1;
            end
            OP_LDX: begin
                dec.ext       = 1'b1;
                dec.last_word = 2'd2;
            end
            OP_HLT: begin
                dec.halt = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        // Wide opcodes with upper bits set do nothing but raise the fault.
        if (op_upper_set) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Next-state and strobe logic; with en low everything holds and the
    // strobes stay at their zero defaults.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        last_word_d = last_word_q;
        tmo_cnt_d   = tmo_cnt_q;
        fault_d     = fault_q;
        alu_ot_c    = ALU_ADDR;
        ins_load_c  = 1'b0;
        op1_load_c  = 1'b0;
        op2_load_c  = 1'b0;
        pc_load_c   = 1'b0;
        pc_inc_c    = 1'b0;
        reg_load_c  = 1'b0;

        if (bus.en) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end

                S_FETCH: begin
                    pc_load_c = 1'b1;
                    state_d   = S_WAIT_INS;
                end

                // A timeout beats a ROM word arriving in the same cycle.
                S_WAIT_INS: begin
                    if (tmo_hit) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else if (bus.ins_valid) begin
                        ins_load_c = 1'b1;
                        state_d    = S_EXEC;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end

                S_EXEC: begin
                    alu_ot_c   = dec.alu_ot;
                    op1_load_c = dec.op1_load;
                    op2_load_c = dec.op2_load;
                    if (dec.illegal) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else if (dec.halt) begin
                        state_d = S_HALT;
                    end else if (dec.alu_wait) begin
                        state_d = S_ALU_WAIT;
                    end else if (dec.ext) begin
                        // The IR is overwritten by later words, so keep
                        // the word count of this instruction.
                        pc_inc_c    = 1'b1;
                        last_word_d = dec.last_word;
                        state_d     = S_EXT_FETCH;
                    end else begin
                        reg_load_c = 1'b1;
                        pc_inc_c   = 1'b1;
                        state_d    = S_FETCH;
                    end
                end

                S_ALU_WAIT: begin
                    alu_ot_c = ALU_ARITH;
                    if (tmo_hit) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else if (bus.alu_done) begin
                        reg_load_c = 1'b1;
                        pc_inc_c   = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end

                S_EXT_FETCH: begin
                    pc_load_c  = 1'b1;
                    word_idx_d = word_idx_q + 2'd1;
                    state_d    = S_EXT_WAIT;
                end

                S_EXT_WAIT: begin
                    if (tmo_hit) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else if (bus.ins_valid) begin
                        ins_load_c = 1'b1;
                        state_d    = S_EXT_EXEC;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end

                S_EXT_EXEC: begin
                    alu_ot_c = ALU_ADDR;
                    pc_inc_c = 1'b1;
                    if (word_idx_q == last_word_q) begin
                        reg_load_c = 1'b1;
                        word_idx_d = 2'd0;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_EXT_FETCH;
                    end
                end

                S_HALT: begin
                    state_d = S_HALT;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Every wait starts with a fresh timeout budget.
            if (is_wait(state_d) && !is_wait(state_q)) begin
                tmo_cnt_d = '0;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q     <= S_IDLE;
            word_idx_q  <= 2'd0;
            last_word_q <= 2'd0;
            tmo_cnt_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            last_word_q <= last_word_d;
            tmo_cnt_q   <= tmo_cnt_d;
            fault_q     <= fault_d;
        end
    end

    // While paused every output except halted/fault reads zero.
    assign bus.alu_ot   = alu_ot_c;
    assign bus.ins_load = ins_load_c;
    assign bus.op1_load = op1_load_c;
    assign bus.op2_load = op2_load_c;
    assign bus.pc_load  = pc_load_c;
    assign bus.pc_inc   = pc_inc_c;
    assign bus.reg_load = reg_load_c;
    assign bus.word_idx = bus.en ? word_idx_q : 2'd0;
    assign bus.busy     = bus.en && (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted   = (state_q == S_HALT);
    assign bus.fault    = fault_q;

endmodule
